// File: rtl/fir_deconv.sv
// Purpose: recovers x[n] from FIR output y[n] via x[n] = y[n] - sum K[i]*x[n-i], one MAC per cycle.
// Latency: sample accepted at edge t shows m_valid after edge t+N+1 (N MAC steps plus output register).
// Backpressure: s_ready only in IDLE; result held in OUT until m_ready, no input/output overlap.
module fir_deconv #(
   parameter int N   = 3,
   parameter int W_X = 4,
   parameter int W_K = 4,
   parameter int W_Y = W_X + W_K + $clog2(N),
   parameter logic signed [W_K-1:0] K [N+1] = '{W_K'(1), W_K'(2), W_K'(3), W_K'(4)}
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clr,
   input  logic signed [W_Y-1:0] s_y,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic signed [W_X-1:0] m_x,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_ovf
);

   localparam int W_ACC = W_Y + W_X + W_K + $clog2(N) + 1;
   localparam int W_P   = W_K + W_X;
   localparam int IW    = $clog2(N + 2);
   localparam logic [IW-1:0] LAST = IW'(N + 1);
   localparam logic signed [W_ACC-1:0] X_MAX = W_ACC'((1 <<< (W_X - 1)) - 1);
   localparam logic signed [W_ACC-1:0] X_MIN = W_ACC'(-(1 <<< (W_X - 1)));

   // The recursion divides by K[0]; only a unit leading tap makes that a plain subtraction.
   if (K[0] != W_K'(1)) begin : g_k0_check
      $error("fir_deconv: K[0] must equal 1");
   end

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                  state, state_nx;
   logic [IW-1:0]           idx;
   logic signed [W_ACC-1:0] acc;
   logic signed [W_X-1:0]   hist [N];
   logic signed [W_K-1:0]   k_sel;
   logic signed [W_X-1:0]   h_sel;
   logic signed [W_P-1:0]   prod;
   logic signed [W_ACC-1:0] acc_nx;
   logic signed [W_X-1:0]   sat_x;
   logic                    sat_ovf;
   logic                    accept;
   logic                    deliver;

   assign accept  = s_valid & s_ready;
   assign deliver = m_valid & m_ready;

   // Select the tap and history entry for the current MAC step (idx runs 1..N).
   always_comb begin
      k_sel = '0;
      h_sel = '0;
      for (int j = 1; j <= N; j++) begin
         if (idx == IW'(j)) begin
            k_sel = K[j];
            h_sel = hist[j-1];
         end
      end
   end

   assign prod   = W_P'(k_sel) * W_P'(h_sel);
   assign acc_nx = acc - W_ACC'(prod);

   // Clamp the finished accumulator to the recovered-sample range.
   always_comb begin
      sat_x   = acc[W_X-1:0];
      sat_ovf = 1'b0;
      if (acc > X_MAX) begin
         sat_x   = {1'b0, {(W_X-1){1'b1}}};
         sat_ovf = 1'b1;
      end else if (acc < X_MIN) begin
         sat_x   = {1'b1, {(W_X-1){1'b0}}};
         sat_ovf = 1'b1;
      end
   end

   // Next-state logic; clr overrides every transition.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = MAC;
         MAC:     if (idx == LAST) state_nx = OUT;
         OUT:     if (deliver) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (clr) state_nx = IDLE;
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   // Datapath: accumulate, register the saturated result, shift history on delivery.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc     <= '0;
         idx     <= '0;
         m_x     <= '0;
         m_ovf   <= 1'b0;
         m_valid <= 1'b0;
         s_ready <= 1'b0;
         for (int j = 0; j < N; j++) hist[j] <= '0;
      end else if (clr) begin
         acc     <= '0;
         idx     <= '0;
         m_ovf   <= 1'b0;
         m_valid <= 1'b0;
         s_ready <= 1'b1;
         for (int j = 0; j < N; j++) hist[j] <= '0;
      end else begin
         // Registered so s_ready stays low until the first edge after reset.
         s_ready <= (state_nx == IDLE);
         case (state)
            IDLE: begin
               if (accept) begin
                  acc <= W_ACC'(s_y);
                  idx <= IW'(1);
               end
            end
            MAC: begin
               if (idx == LAST) begin
                  m_x     <= sat_x;
                  m_ovf   <= sat_ovf;
                  m_valid <= 1'b1;
               end else begin
                  acc <= acc_nx;
                  idx <= idx + 1'b1;
               end
            end
            OUT: begin
               if (deliver) begin
                  m_valid <= 1'b0;
                  hist[0] <= m_x;
                  for (int j = 1; j < N; j++) hist[j] <= hist[j-1];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
